// File: rtl/alarm_rtc_pkg.sv
// Shared types and constants for the alarm RTC core: ring FSM states,
// register addresses, alarm register field positions and field widths.
package alarm_rtc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } ring_state_t;

  localparam logic [3:0] ADDR_SEC        = 4'd0;
  localparam logic [3:0] ADDR_MIN        = 4'd1;
  localparam logic [3:0] ADDR_HOUR       = 4'd2;
  localparam logic [3:0] ADDR_ALARM_BASE = 4'd4;

  // Alarm register layout: bit15 enable, bits12:8 hour, bits5:0 minute.
  localparam int ALM_EN_BIT   = 15;
  localparam int ALM_HOUR_MSB = 12;
  localparam int ALM_HOUR_LSB = 8;
  localparam int ALM_MIN_MSB  = 5;
  localparam int ALM_MIN_LSB  = 0;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

endpackage

// File: rtl/alarm_ring_fsm.sv
// Ring state machine: IDLE / RINGING / SNOOZED with snooze and ring-timeout
// counters, both decremented once per 1 Hz tick. The current state is
// exported on state_o; "ringing" is simply state_o == RINGING and is decoded
// by the parent, which also owns the optional beep gating.
module alarm_ring_fsm
  import alarm_rtc_pkg::*;
#(
  parameter int NUM_ALARMS     = 4,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 300
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tick_i,
  input  logic [NUM_ALARMS-1:0] match_i,
  input  logic                  snooze_i,
  input  logic                  dismiss_i,
  output ring_state_t           state_o,
  output logic [NUM_ALARMS-1:0] active_o
);

  localparam int TO_W = $clog2(RING_TIMEOUT_S + 1);
  localparam int SN_W = $clog2(SNOOZE_MIN * 60 + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(RING_TIMEOUT_S);
  localparam logic [SN_W-1:0] SN_LOAD = SN_W'(SNOOZE_MIN * 60);

  ring_state_t           state_q, state_d;
  logic [NUM_ALARMS-1:0] active_q, active_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic [SN_W-1:0]       sn_q, sn_d;
  logic                  hit;

  assign hit = tick_i && (|match_i);

  // State, latched alarm mask and both counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      active_q <= '0;
      to_q     <= '0;
      sn_q     <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      to_q     <= to_d;
      sn_q     <= sn_d;
    end
  end

  // Next state. Dismiss beats snooze; a counter at 1 expires on this tick.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    to_d     = to_q;
    sn_d     = sn_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          state_d  = RINGING;
          active_d = match_i;
          to_d     = TO_LOAD;
        end
      end
      RINGING: begin
        if (dismiss_i) begin
          state_d  = IDLE;
          active_d = '0;
        end else if (snooze_i) begin
          state_d = SNOOZED;
          sn_d    = SN_LOAD;
          if (hit) active_d = active_q | match_i;
        end else if (hit) begin
          active_d = active_q | match_i;
          to_d     = TO_LOAD;
        end else if (tick_i) begin
          if (to_q <= TO_W'(1)) begin
            state_d  = IDLE;
            active_d = '0;
            to_d     = '0;
          end else begin
            to_d = to_q - TO_W'(1);
          end
        end
      end
      SNOOZED: begin
        if (dismiss_i) begin
          state_d  = IDLE;
          active_d = '0;
        end else if (hit) begin
          state_d  = RINGING;
          active_d = active_q | match_i;
          to_d     = TO_LOAD;
        end else if (tick_i) begin
          if (sn_q <= SN_W'(1)) begin
            state_d = RINGING;
            sn_d    = '0;
            to_d    = TO_LOAD;
          end else begin
            sn_d = sn_q - SN_W'(1);
          end
        end
      end
      default: begin
        state_d  = IDLE;
        active_d = '0;
      end
    endcase
  end

  assign state_o  = state_q;
  assign active_o = active_q;

endmodule

// File: rtl/alarm_rtc_core.sv
// Timekeeping and alarm engine: 1 Hz prescaler, 24 h time registers,
// NUM_ALARMS alarm registers, match compare and the ring FSM.
// Optional build macro ALARM_BEEP_EN: when defined the ring output beeps at
// 1 Hz (high in the first half of each second); otherwise it is steady high.
//
// Write port: wr_en is a single-cycle strobe with no ready/back-pressure; a
// write is taken on the clock edge where wr_en is high, and values out of
// range for the addressed register are dropped without any side effect.
module alarm_rtc_core
  import alarm_rtc_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int NUM_ALARMS     = 4,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 300
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [15:0]           wr_data,
  input  logic                  snooze_in,
  input  logic                  dismiss_in,
  output logic [15:0]           seconds_export,
  output logic [15:0]           minutes_export,
  output logic [15:0]           hours_export,
  output logic                  alarm_export,
  output logic [NUM_ALARMS-1:0] alarm_active,
  output logic                  tick_1hz
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;

  logic [NUM_ALARMS-1:0] alm_en_q, alm_en_d;
  logic [HOUR_W-1:0]     alm_hour_q [NUM_ALARMS];
  logic [HOUR_W-1:0]     alm_hour_d [NUM_ALARMS];
  logic [MIN_W-1:0]      alm_min_q  [NUM_ALARMS];
  logic [MIN_W-1:0]      alm_min_d  [NUM_ALARMS];

  logic                  tick, advance;
  logic                  wr_sec_ok, wr_min_ok, wr_hour_ok, time_wr, alm_wr_ok;
  logic [HOUR_W-1:0]     wr_alm_hour;
  logic [MIN_W-1:0]      wr_alm_min;
  logic [NUM_ALARMS-1:0] match_mask;
  ring_state_t           ring_state;

  assign tick = (presc_q == PRESC_LAST);

  assign wr_sec_ok  = wr_en && (wr_addr == ADDR_SEC)  && (wr_data <= 16'd59);
  assign wr_min_ok  = wr_en && (wr_addr == ADDR_MIN)  && (wr_data <= 16'd59);
  assign wr_hour_ok = wr_en && (wr_addr == ADDR_HOUR) && (wr_data <= 16'd23);
  assign time_wr    = wr_sec_ok || wr_min_ok || wr_hour_ok;
  // A time write on a tick replaces that tick's increment entirely.
  assign advance    = tick && !time_wr;

  assign wr_alm_hour = wr_data[ALM_HOUR_MSB:ALM_HOUR_LSB];
  assign wr_alm_min  = wr_data[ALM_MIN_MSB:ALM_MIN_LSB];
  assign alm_wr_ok   = wr_en && (wr_alm_hour <= 5'd23) && (wr_alm_min <= 6'd59);

  // Prescaler, time and alarm registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      presc_q  <= '0;
      sec_q    <= '0;
      min_q    <= '0;
      hour_q   <= '0;
      alm_en_q <= '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        alm_hour_q[k] <= '0;
        alm_min_q[k]  <= '0;
      end
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      alm_en_q   <= alm_en_d;
      alm_hour_q <= alm_hour_d;
      alm_min_q  <= alm_min_d;
    end
  end

  // Prescaler wraps on the tick; an accepted seconds write restarts the second.
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (wr_sec_ok || tick) presc_d = '0;
  end

  // Time next-state: register write wins over the tick increment and carries.
  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (time_wr) begin
      if (wr_sec_ok)  sec_d  = wr_data[SEC_W-1:0];
      if (wr_min_ok)  min_d  = wr_data[MIN_W-1:0];
      if (wr_hour_ok) hour_d = wr_data[HOUR_W-1:0];
    end else if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d  = '0;
          hour_d = (hour_q == 5'd23) ? '0 : hour_q + HOUR_W'(1);
        end else begin
          min_d = min_q + MIN_W'(1);
        end
      end else begin
        sec_d = sec_q + SEC_W'(1);
      end
    end
  end

  // Alarm register writes; addresses past the last implemented alarm never match.
  always_comb begin
    alm_en_d   = alm_en_q;
    alm_hour_d = alm_hour_q;
    alm_min_d  = alm_min_q;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (alm_wr_ok && (wr_addr == ADDR_ALARM_BASE + 4'(k))) begin
        alm_en_d[k]   = wr_data[ALM_EN_BIT];
        alm_hour_d[k] = wr_alm_hour;
        alm_min_d[k]  = wr_alm_min;
      end
    end
  end

  // Match against the post-increment time, only when the tick really advanced.
  always_comb begin
    match_mask = '0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      match_mask[k] = advance && alm_en_q[k] && (alm_hour_q[k] == hour_d) &&
                      (alm_min_q[k] == min_d) && (sec_d == '0);
    end
  end

  alarm_ring_fsm #(
    .NUM_ALARMS     (NUM_ALARMS),
    .SNOOZE_MIN     (SNOOZE_MIN),
    .RING_TIMEOUT_S (RING_TIMEOUT_S)
  ) u_ring (
    .clk_i     (clk_clk),
    .rst_ni    (reset_reset_n),
    .tick_i    (tick),
    .match_i   (match_mask),
    .snooze_i  (snooze_in),
    .dismiss_i (dismiss_in),
    .state_o   (ring_state),
    .active_o  (alarm_active)
  );

`ifdef ALARM_BEEP_EN
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
  assign alarm_export = (ring_state == RINGING) && (presc_q < PRESC_HALF);
`else
  assign alarm_export = (ring_state == RINGING);
`endif

  assign seconds_export = {{(16-SEC_W){1'b0}}, sec_q};
  assign minutes_export = {{(16-MIN_W){1'b0}}, min_q};
  assign hours_export   = {{(16-HOUR_W){1'b0}}, hour_q};
  assign tick_1hz       = tick;

endmodule

// File: tb/tb_alarm_rtc_core.sv
// Bench for alarm_rtc_core with CLK_HZ=10, SNOOZE_MIN=1, RING_TIMEOUT_S=20.
// Stimulus pushes hand-computed expected output snapshots into a queue; a
// negedge monitor pops and compares them against the live outputs.
module tb_alarm_rtc_core;

  localparam int W = 16 * 3 + 1 + 4 + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        snooze, dismiss;
  logic [15:0] sec_o, min_o, hour_o;
  logic        alarm_o, tick_o;
  logic [3:0]  active_o;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  alarm_rtc_core #(
    .CLK_HZ(10), .NUM_ALARMS(4), .SNOOZE_MIN(1), .RING_TIMEOUT_S(20)
  ) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .snooze_in      (snooze),
    .dismiss_in     (dismiss),
    .seconds_export (sec_o),
    .minutes_export (min_o),
    .hours_export   (hour_o),
    .alarm_export   (alarm_o),
    .alarm_active   (active_o),
    .tick_1hz       (tick_o)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(int s, int m, int h, bit al,
                                        logic [3:0] act, bit tk);
    pack = {16'(s), 16'(m), 16'(h), al, act, tk};
  endfunction

  // Queue an expected snapshot; use_tk=0 ignores tick_1hz.
  task automatic chk(string n, int s, int m, int h, bit al, logic [3:0] act,
                     bit tk, bit use_tk);
    exp_q.push_back(pack(s, m, h, al, act, tk));
    mask_q.push_back({{(W-1){1'b1}}, use_tk});
    name_q.push_back(n);
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [3:0] a, logic [15:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse(bit sn, bit dm);
    @(posedge clk); #1;
    snooze = sn; dismiss = dm;
    @(posedge clk); #1;
    snooze = 1'b0; dismiss = 1'b0;
  endtask

  // Monitor: compare every pending expectation against the outputs.
  always @(negedge clk) begin
    logic [W-1:0] e, m, a;
    string        n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      n = name_q.pop_front();
      a = {sec_o, min_o, hour_o, alarm_o, active_o, tick_o};
      checks++;
      if ((a & m) !== (e & m)) begin
        errors++;
        $display("FAIL %s: got {sec,min,hour,ring,active,tick}=%h expected %h",
                 n, a & m, e & m);
      end
    end
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    snooze = 1'b0; dismiss = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("reset", 0, 0, 0, 0, 4'b0000, 0, 1);
    cyc(1);
    rst_n = 1'b1;

    // Carry chain through midnight, tick every 10 cycles.
    wr(4'd2, 16'd23); wr(4'd1, 16'd59); wr(4'd0, 16'd58);
    chk("t1_start", 58, 59, 23, 0, 4'b0000, 0, 1);
    cyc(9);  chk("t1_tick_a", 58, 59, 23, 0, 4'b0000, 1, 1);
    cyc(1);  chk("t1_sec59",  59, 59, 23, 0, 4'b0000, 0, 1);
    cyc(9);  chk("t1_tick_b", 59, 59, 23, 0, 4'b0000, 1, 1);
    cyc(1);  chk("t1_wrap",    0,  0,  0, 0, 4'b0000, 0, 1);

    // Out-of-range writes are dropped; bad seconds must not clear the prescaler.
    wr(4'd1, 16'd60); wr(4'd2, 16'd24);
    chk("t2_bad_min_hour", 0, 0, 0, 0, 4'b0000, 0, 0);
    wr(4'd0, 16'd60);
    cyc(3);  chk("t2_bad_sec_tick", 0, 0, 0, 0, 4'b0000, 1, 1);
    cyc(1);  chk("t2_sec1",         1, 0, 0, 0, 4'b0000, 0, 1);

    // Alarm 2 at 07:30 fires one tick after 07:29:59.
    wr(4'd6, 16'h871E); wr(4'd2, 16'd7); wr(4'd1, 16'd29); wr(4'd0, 16'd59);
    chk("t3_set", 59, 29, 7, 0, 4'b0000, 0, 1);
    cyc(9);  chk("t3_pre",  59, 29, 7, 0, 4'b0000, 1, 1);
    cyc(1);  chk("t3_ring",  0, 30, 7, 1, 4'b0100, 0, 1);

    // Snooze: silent for 60 ticks, mask held, then rings again.
    pulse(1, 0);
    chk("t4_snoozed", 0, 30, 7, 0, 4'b0100, 0, 1);
    cyc(597); chk("t4_pre_rering", 59, 30, 7, 0, 4'b0100, 1, 1);
    cyc(1);   chk("t4_rering",      0, 31, 7, 1, 4'b0100, 0, 1);

    // Snooze and dismiss together: dismiss wins, no re-ring.
    pulse(1, 1);
    chk("t5_dismiss", 0, 31, 7, 0, 4'b0000, 0, 1);
    cyc(600); chk("t5_no_rering", 0, 32, 7, 0, 4'b0000, 0, 1);

    // Alarm 0 at 07:40; invalid overwrite (minute 61) keeps the old value.
    // Direct writes to 07:40:00 (the seconds one landing on a tick) don't fire.
    wr(4'd4, 16'h8728); wr(4'd4, 16'h873D); wr(4'd1, 16'd40); wr(4'd0, 16'd0);
    chk("t6_write_wins", 0, 40, 7, 0, 4'b0000, 0, 1);
    cyc(10);  chk("t6_no_fire", 1, 40, 7, 0, 4'b0000, 0, 1);
    wr(4'd1, 16'd39); wr(4'd0, 16'd59);
    cyc(10);  chk("t6_ring", 0, 40, 7, 1, 4'b0001, 0, 1);
    cyc(199); chk("t6_pre_timeout", 19, 40, 7, 1, 4'b0001, 1, 1);
    cyc(1);   chk("t6_timeout",     20, 40, 7, 0, 4'b0000, 0, 1);

    // Asynchronous reset mid-ring clears everything before the next edge.
    wr(4'd1, 16'd39); wr(4'd0, 16'd59);
    cyc(10);  chk("t7_ring", 0, 40, 7, 1, 4'b0001, 0, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    chk("t7_async_reset", 0, 0, 0, 0, 4'b0000, 0, 1);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);   chk("t7_after_reset", 0, 0, 0, 0, 4'b0000, 0, 1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d expectations never compared, required 0", exp_q.size());
      errors += exp_q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
